// File: rtl/image_write_buffer_pkg.sv
// Shared definitions for the image write buffer: FSM encoding, byte offsets
// inside a pixel pair and the bottom-up BMP address helper.
package image_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READOUT = 2'd2
    } state_e;

    localparam int OFF_R      = 0;
    localparam int OFF_G      = 1;
    localparam int OFF_B      = 2;
    localparam int PAIR_BYTES = 6;

    // Row 0 of the incoming image is the top line, which BMP stores last.
    function automatic int unsigned bmp_addr(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned width,
                                             input int unsigned height);
        return width * 3 * (height - 1 - row) + 3 * col;
    endfunction

endpackage

// File: rtl/image_write_buffer_if.sv
// Pixel-pair capture stream, byte readout handshake and status flags of the
// image write buffer, bundled for the DUT (slave) and its environment (master).
interface image_write_buffer_if;

    logic       VSYNC;
    logic       HSYNC;
    logic [7:0] DATA_R0;
    logic [7:0] DATA_G0;
    logic [7:0] DATA_B0;
    logic [7:0] DATA_R1;
    logic [7:0] DATA_G1;
    logic [7:0] DATA_B1;
    logic       write_done;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       err_overrun;
    logic       err_short;

    modport slave (
        input  VSYNC, HSYNC,
        input  DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1,
        input  rd_ready,
        output write_done, rd_valid, rd_data, rd_last, err_overrun, err_short
    );

    modport master (
        output VSYNC, HSYNC,
        output DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1,
        output rd_ready,
        input  write_done, rd_valid, rd_data, rd_last, err_overrun, err_short
    );

endinterface

// File: rtl/image_write_buffer_frame_buffer_ram.sv
// Frame buffer storage: one pixel pair (6 bytes) written per clock at a base
// address, one byte read combinationally.
module frame_buffer_ram
    import image_pkg::*;
#(
    parameter int DEPTH = 150,
    parameter int AW    = 8
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [AW-1:0]           waddr_i,
    input  logic [8*PAIR_BYTES-1:0] wdata_i,
    input  logic [AW-1:0]           raddr_i,
    output logic [7:0]              rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // Contents are deliberately left unreset; every frame overwrites them.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < PAIR_BYTES; i++) begin
                mem_q[waddr_i + AW'(i)] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/image_write_buffer.sv
// Captures a 2-pixel-per-clock RGB888 frame into a bottom-up BMP ordered
// buffer, then streams it out byte by byte over a valid/ready handshake.
module image_write_buffer
    import image_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 5
) (
    input  logic               HCLK,
    input  logic               HRESET,
    image_write_buffer_if.slave bus
);

    localparam int IMAGE_BYTES = WIDTH * HEIGHT * 3;
    localparam int PAIRS       = WIDTH * HEIGHT / 2;
    localparam int ADDR_W      = (IMAGE_BYTES > 1) ? $clog2(IMAGE_BYTES) : 1;
    localparam int ROW_W       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int COL_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W       = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_BYTES - 1);
    localparam logic [CNT_W-1:0]  LAST_PAIR = CNT_W'(PAIRS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 2);

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                write_done_q, write_done_d;
    logic                err_overrun_q, err_overrun_d;
    logic                err_short_q, err_short_d;

    logic                    we;
    logic [ADDR_W-1:0]       waddr;
    logic [8*PAIR_BYTES-1:0] wdata;
    logic [7:0]              rd_byte;

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            col_q         <= '0;
            cnt_q         <= '0;
            rd_addr_q     <= '0;
            write_done_q  <= 1'b0;
            err_overrun_q <= 1'b0;
            err_short_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            cnt_q         <= cnt_d;
            rd_addr_q     <= rd_addr_d;
            write_done_q  <= write_done_d;
            err_overrun_q <= err_overrun_d;
            err_short_q   <= err_short_d;
        end
    end

    // VSYNC has priority over HSYNC in CAPTURE so a restart always drops the pair.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        cnt_d         = cnt_q;
        rd_addr_d     = rd_addr_q;
        write_done_d  = 1'b0;
        err_overrun_d = err_overrun_q;
        err_short_d   = err_short_q;
        we            = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.HSYNC) begin
                    err_overrun_d = 1'b1;
                end
                if (bus.VSYNC) begin
                    state_d = ST_CAPTURE;
                    row_d   = '0;
                    col_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_CAPTURE: begin
                if (bus.VSYNC) begin
                    if (cnt_q != '0) begin
                        err_short_d = 1'b1;
                    end
                    row_d = '0;
                    col_d = '0;
                    cnt_d = '0;
                end else if (bus.HSYNC) begin
                    we = 1'b1;
                    if (cnt_q == LAST_PAIR) begin
                        state_d      = ST_READOUT;
                        write_done_d = 1'b1;
                        row_d        = '0;
                        col_d        = '0;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(2);
                        end
                    end
                end
            end
            ST_READOUT: begin
                if (bus.HSYNC || bus.VSYNC) begin
                    err_overrun_d = 1'b1;
                end
                if (bus.rd_ready) begin
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_addr_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wdata                            = '0;
        wdata[8*OFF_R +: 8]              = bus.DATA_R0;
        wdata[8*OFF_G +: 8]              = bus.DATA_G0;
        wdata[8*OFF_B +: 8]              = bus.DATA_B0;
        wdata[8*(3 + OFF_R) +: 8]        = bus.DATA_R1;
        wdata[8*(3 + OFF_G) +: 8]        = bus.DATA_G1;
        wdata[8*(3 + OFF_B) +: 8]        = bus.DATA_B1;
    end

    assign waddr = ADDR_W'(bmp_addr(32'(row_q), 32'(col_q), WIDTH, HEIGHT));

    frame_buffer_ram #(
        .DEPTH (IMAGE_BYTES),
        .AW    (ADDR_W)
    ) u_ram (
        .clk_i   (HCLK),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (rd_addr_q),
        .rdata_o (rd_byte)
    );

    assign bus.rd_valid    = (state_q == ST_READOUT);
    assign bus.rd_last     = (state_q == ST_READOUT) && (rd_addr_q == LAST_ADDR);
    assign bus.rd_data     = rd_byte;
    assign bus.write_done  = write_done_q;
    assign bus.err_overrun = err_overrun_q;
    assign bus.err_short   = err_short_q;

endmodule

// File: tb/tb_image_write_buffer.sv
// Scoreboard bench for image_write_buffer: a byte-order model of the BMP frame
// feeds an expected queue that a free-running monitor drains on each handshake.
module tb_image_write_buffer;

    localparam int WIDTH       = 10;
    localparam int HEIGHT      = 5;
    localparam int IMAGE_BYTES = WIDTH * HEIGHT * 3;

    logic clk;
    logic rst_n;

    image_write_buffer_if bus ();

    image_write_buffer #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) dut (
        .HCLK   (clk),
        .HRESET (rst_n),
        .bus    (bus)
    );

    int checks;
    int errors;
    int hsCount;
    int readyMode;

    logic [7:0] pix [HEIGHT][WIDTH][3];
    logic [7:0] expQ [$];
    bit         lastQ [$];

    logic       prevHold;
    logic [7:0] prevData;
    logic       prevLast;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Rotating ready: 0 = always high, 1 = pattern 1,0,0,1, 2 = random.
    initial begin
        int phase;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        phase = 0;
        bus.rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                1: begin
                    bus.rd_ready = pat[phase];
                    phase = (phase + 1) % 4;
                end
                2: bus.rd_ready = 1'($urandom_range(0, 1));
                default: bus.rd_ready = 1'b1;
            endcase
        end
    end

    // Monitor: every accepted byte is compared with the head of the scoreboard,
    // and a stalled byte must not change until it is taken.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevHold = 1'b0;
        end else begin
            if (prevHold && bus.rd_valid) begin
                checkOutput("stall_data", bus.rd_data, prevData);
                checkOutput("stall_last", bus.rd_last, prevLast);
            end
            if (bus.rd_valid && bus.rd_ready) begin
                hsCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_byte", 1, 0);
                end else begin
                    checkOutput("rd_data", bus.rd_data, expQ.pop_front());
                    checkOutput("rd_last", bus.rd_last, lastQ.pop_front());
                end
            end
            prevHold = bus.rd_valid && !bus.rd_ready;
            prevData = bus.rd_data;
            prevLast = bus.rd_last;
        end
    end

    task automatic fillPixels(input bit kPattern);
        for (int y = 0; y < HEIGHT; y++)
            for (int x = 0; x < WIDTH; x++)
                for (int c = 0; c < 3; c++)
                    pix[y][x][c] = 8'($urandom_range(0, 255));
        if (kPattern) begin
            for (int k = 0; k < WIDTH * HEIGHT / 2; k++) begin
                int y;
                int x;
                y = k / (WIDTH / 2);
                x = 2 * (k % (WIDTH / 2));
                pix[y][x][0]     = 8'(k);
                pix[y][x][1]     = 8'(k + 64);
                pix[y][x][2]     = 8'(k + 128);
                pix[y][x + 1][0] = 8'(k + 32);
                pix[y][x + 1][1] = 8'(k + 96);
                pix[y][x + 1][2] = 8'(k + 160);
            end
        end
    endtask

    // Reference: walk the output byte stream; BMP stores the bottom line first.
    task automatic pushModel();
        for (int a = 0; a < IMAGE_BYTES; a++) begin
            int y;
            int x;
            y = HEIGHT - 1 - a / (WIDTH * 3);
            x = (a % (WIDTH * 3)) / 3;
            expQ.push_back(pix[y][x][a % 3]);
            lastQ.push_back(a == IMAGE_BYTES - 1);
        end
    endtask

    task automatic drivePair(input int y, input int x);
        bus.HSYNC   = 1'b1;
        bus.DATA_R0 = pix[y][x][0];
        bus.DATA_G0 = pix[y][x][1];
        bus.DATA_B0 = pix[y][x][2];
        bus.DATA_R1 = pix[y][x + 1][0];
        bus.DATA_G1 = pix[y][x + 1][1];
        bus.DATA_B1 = pix[y][x + 1][2];
    endtask

    task automatic driveJunk();
        bus.HSYNC   = 1'b1;
        bus.DATA_R0 = 8'($urandom);
        bus.DATA_G0 = 8'($urandom);
        bus.DATA_B0 = 8'($urandom);
        bus.DATA_R1 = 8'($urandom);
        bus.DATA_G1 = 8'($urandom);
        bus.DATA_B1 = 8'($urandom);
    endtask

    task automatic vsyncPulse(input int cycles);
        bus.HSYNC = 1'b0;
        bus.VSYNC = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        bus.VSYNC = 1'b0;
    endtask

    task automatic waitReadout();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 4000 && !done; n++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !bus.rd_valid) done = 1'b1;
        end
        if (!done) begin
            checkOutput("readout_timeout", 0, 1);
            expQ.delete();
            lastQ.delete();
        end
    endtask

    // One frame: optional aborted prefix, VSYNC, all pairs with row gaps,
    // optional overrun injection, then readout or a reset at byte abortAt.
    task automatic applyStimulus(input bit kPattern, input int gap, input bit gapRand,
                                 input int shortPairs, input bit injectOverrun, input int abortAt);
        @(posedge clk);
        #1;
        fillPixels(kPattern);
        if (shortPairs > 0) begin
            vsyncPulse(2);
            for (int p = 0; p < shortPairs; p++) begin
                driveJunk();
                @(posedge clk);
                #1;
            end
        end
        pushModel();
        hsCount = 0;
        vsyncPulse(3);
        for (int y = 0; y < HEIGHT; y++) begin
            if (y > 0 && gap > 0) begin
                int g;
                g = gapRand ? int'($urandom_range(0, gap)) : gap;
                bus.HSYNC = 1'b0;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            for (int x = 0; x < WIDTH; x += 2) begin
                drivePair(y, x);
                @(posedge clk);
                #1;
            end
        end
        bus.HSYNC = 1'b0;
        @(negedge clk);
        checkOutput("write_done_pulse", bus.write_done, 1);
        checkOutput("first_byte_valid", bus.rd_valid, 1);
        @(negedge clk);
        checkOutput("write_done_width", bus.write_done, 0);
        if (injectOverrun) begin
            @(posedge clk);
            #1;
            driveJunk();
            bus.VSYNC = 1'b1;
            @(posedge clk);
            #1;
            bus.VSYNC = 1'b0;
            @(posedge clk);
            #1;
            bus.HSYNC = 1'b0;
            @(negedge clk);
            checkOutput("overrun_in_readout", bus.err_overrun, 1);
        end
        if (abortAt >= 0) begin
            bit hit;
            hit = 1'b0;
            for (int n = 0; n < 4000 && !hit; n++) begin
                @(negedge clk);
                #1;
                if (hsCount >= abortAt) hit = 1'b1;
            end
            if (!hit) checkOutput("abort_timeout", 0, 1);
            rst_n = 1'b0;
            #1;
            checkOutput("reset_rd_valid", bus.rd_valid, 0);
            checkOutput("reset_overrun", bus.err_overrun, 0);
            checkOutput("reset_short", bus.err_short, 0);
            expQ.delete();
            lastQ.delete();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end else begin
            waitReadout();
            checkOutput("handshakes", hsCount, IMAGE_BYTES);
        end
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        hsCount   = 0;
        readyMode = 0;
        prevHold  = 1'b0;
        rst_n     = 1'b0;
        bus.VSYNC   = 1'b0;
        bus.HSYNC   = 1'b0;
        bus.DATA_R0 = '0;
        bus.DATA_G0 = '0;
        bus.DATA_B0 = '0;
        bus.DATA_R1 = '0;
        bus.DATA_G1 = '0;
        bus.DATA_B1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_valid", bus.rd_valid, 0);
        checkOutput("reset_write_done", bus.write_done, 0);
        checkOutput("reset_last", bus.rd_last, 0);
        checkOutput("reset_err_overrun", bus.err_overrun, 0);
        checkOutput("reset_err_short", bus.err_short, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] clean k-pattern frame");
        applyStimulus(1'b1, 0, 1'b0, 0, 1'b0, -1);
        $display("[TB] k-pattern frame with 160-cycle line gaps");
        applyStimulus(1'b1, 160, 1'b0, 0, 1'b0, -1);
        $display("[TB] backpressure 1,0,0,1");
        readyMode = 1;
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, -1);
        $display("[TB] random ready and random gaps");
        readyMode = 2;
        applyStimulus(1'b0, 20, 1'b1, 0, 1'b0, -1);
        checkOutput("no_overrun_yet", bus.err_overrun, 0);
        checkOutput("no_short_yet", bus.err_short, 0);

        $display("[TB] restart after 7 pairs");
        readyMode = 0;
        applyStimulus(1'b1, 0, 1'b0, 7, 1'b0, -1);
        checkOutput("err_short_set", bus.err_short, 1);
        checkOutput("err_overrun_clear", bus.err_overrun, 0);

        $display("[TB] HSYNC in IDLE and during readout");
        @(posedge clk);
        #1;
        driveJunk();
        @(posedge clk);
        #1;
        bus.HSYNC = 1'b0;
        @(negedge clk);
        checkOutput("overrun_in_idle", bus.err_overrun, 1);
        checkOutput("idle_stays_idle", bus.rd_valid, 0);
        readyMode = 2;
        applyStimulus(1'b0, 5, 1'b1, 0, 1'b1, -1);

        $display("[TB] reset mid-readout");
        readyMode = 0;
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 40);
        applyStimulus(1'b1, 3, 1'b1, 0, 1'b0, -1);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/image_write_buffer.md
Name: image_write_buffer

Overview:
- Downstream stage of the pixel-pair image reader/processor.
- Captures the processed 2-pixel-per-clock RGB888 stream (VSYNC/HSYNC framed) into an on-chip frame buffer. The buffer uses bottom-up BMP row order, matching the hex image format.
- After a complete frame it streams the buffer out byte-serially over a valid/ready interface to the file-dump or UART stage.

Parameters:
- WIDTH, 10, image width in pixels; must be even.
- HEIGHT, 5, image height in pixels.
- IMAGE_BYTES, WIDTH*HEIGHT*3, frame buffer size in bytes (derived; do not override).

Ports:
- HCLK  input  1  clock; all logic on rising edge.
- HRESET  input  1  asynchronous active-low reset.
- VSYNC  input  1  frame-start indicator from the upstream stage (high during its startup period).
- HSYNC  input  1  pixel-pair valid; one pair per high cycle.
- DATA_R0 / DATA_G0 / DATA_B0  input  8 each  even pixel R/G/B.
- DATA_R1 / DATA_G1 / DATA_B1  input  8 each  odd pixel R/G/B.
- write_done  output  1  one-cycle pulse when a full frame has been captured.
- rd_valid  output  1  readout byte valid.
- rd_ready  input  1  consumer accepts byte.
- rd_data  output  8  readout byte.
- rd_last  output  1  high with the final byte (address IMAGE_BYTES-1).
- err_overrun  output  1  sticky; pixel data or VSYNC arrived while not accepting.
- err_short  output  1  sticky; new VSYNC arrived mid-capture.

Behaviour:
- Reset values:
  - state IDLE; row, col, pair count and rd_addr all 0.
  - write_done, rd_valid, rd_last, err_overrun, err_short = 0; rd_data = mem[0] (don't-care).
  - Frame buffer contents are not reset.
- FSM states IDLE, CAPTURE, READOUT.
- IDLE:
  - VSYNC=1 → CAPTURE; row, col and count cleared.
  - HSYNC=1 → data dropped, err_overrun set.
- CAPTURE:
  - Each HSYNC=1 cycle writes 6 bytes in the same edge at base = WIDTH*3*(HEIGHT-1-row) + 3*col:
    - base+0/1/2 = R0/G0/B0;
    - base+3/4/5 = R1/G1/B1.
  - Then col += 2. At col == WIDTH-2: col ← 0, row += 1.
  - HSYNC low cycles (line gaps) hold all counters.
  - On the edge storing pair WIDTH*HEIGHT/2-1 → READOUT next cycle. write_done is high for exactly that first READOUT cycle.
  - VSYNC=1 with count > 0 → err_short set; counters cleared; stay in CAPTURE. This restarts the frame; buffer contents are simply overwritten.
  - VSYNC=1 and HSYNC=1 in the same cycle: VSYNC wins and the data is dropped.
- READOUT:
  - rd_valid = 1; rd_data = mem[rd_addr], combinational read; rd_last = (rd_addr == IMAGE_BYTES-1).
  - rd_data and rd_last are stable while rd_valid && !rd_ready.
  - On rd_valid && rd_ready: rd_addr += 1. At the last byte: rd_addr ← 0, state → IDLE, rd_valid = 0 next cycle.
  - HSYNC=1 or VSYNC=1 during READOUT → ignored, err_overrun set; the frame is not corrupted.
- Latency:
  - First byte is available 1 cycle after the last pair is written.
  - Readout throughput is 1 byte per cycle with rd_ready held high, i.e. IMAGE_BYTES cycles.
- Width rules:
  - row, col and rd_addr use $clog2 of their ranges.
  - Address arithmetic is done at the rd_addr width with no truncation; IMAGE_BYTES ≤ 2^20.
- Reset mid-operation: everything returns to IDLE immediately (async); the error flags clear.

Decomposition:
- Shared package `image_pkg`:
  - FSM state encoding;
  - byte-offset constants R/G/B = 0/1/2 and PAIR_BYTES = 6;
  - a function computing the BMP byte address from (row, col, WIDTH, HEIGHT).
- One sub-module, `frame_buffer_ram`:
  - IMAGE_BYTES x 8;
  - 6-byte-wide write port (base address, 48-bit data, we);
  - 1-byte asynchronous read port.

Test Plan:
- Full frame, 10x5, pairs k=0..24 with R0=k, G0=k+64, B0=k+128, R1=k+32, G1=k+96, B1=k+160, rd_ready=1:
  - write_done pulses once;
  - first bytes out are 20, 84, 148, 52, 116, 180 (row 4 lands at address 0);
  - byte 120 = 0;
  - rd_last coincides with byte 149 = 4+160 = 164;
  - then IDLE.
- Line gaps of 160 HSYNC-low cycles between rows → identical buffer to the gapless case; counters hold during gaps.
- Backpressure: rd_ready toggled 1,0,0,1 → each byte is presented until accepted; no byte skipped or repeated; exactly 150 handshakes.
- VSYNC pulse after 7 pairs, then a full frame → err_short=1; final readout equals the clean-frame result.
- HSYNC=1 in IDLE and during READOUT → err_overrun=1; readout data unchanged.
- HRESET low for 1 cycle mid-READOUT (byte 40) → rd_valid=0 immediately, error flags 0; a new frame is then captured and read from byte 0.
